// File: rtl/fmul_seq.sv
// rtl/fmul_seq.sv - multi-cycle IEEE-754 multiplier with shift-add mantissa datapath
//
// Purpose: multiplies a by b one multiplier bit per cycle, then normalizes,
// rounds and range-checks the product in a single ROUND cycle. Operand format,
// round_mode encoding and flag vector match the FP divider.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any in-flight operation)
//   in_valid   operands valid; accepted when in_ready is high
//   in_ready   high only in IDLE
//   a, b       multiplicand / multiplier
//   round_mode 1: nearest-even, 0: truncate
//   out_valid  r/flags valid; held until out_ready
//   out_ready  consumer accepts result
//   r          product
//   flags      [4] invalid, [3] div_by_0 (0), [2] overflow, [1] underflow, [0] inexact

module fmul_seq #(
  parameter int exp   = 8,
  parameter int frac  = 23,
  parameter int width = exp + frac + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] r,
  output logic [4:0]       flags
);

  localparam int pw   = 2 * frac + 2;        // product width
  localparam int mw   = frac + 1;            // mantissa width incl. hidden bit
  localparam int ew   = exp + 2;             // working exponent width (two's complement)
  localparam int cw   = $clog2(frac + 1);    // bit counter width
  localparam int bias = 2 ** (exp - 1) - 1;

  localparam logic [ew-1:0] e_bias = ew'(bias);
  localparam logic [ew-1:0] e_max  = ew'(2 ** exp - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [cw-1:0]      cnt_q, cnt_d;
  logic [mw-1:0]      mant_a_q, mant_a_d;
  logic [mw-1:0]      mant_b_q, mant_b_d;
  logic [pw-1:0]      prod_q, prod_d;
  logic [ew-1:0]      e_q, e_d;
  logic               sign_q, sign_d;
  logic               rnd_q, rnd_d;
  logic               out_valid_q, out_valid_d;
  logic [width-1:0]   r_q, r_d;
  logic [4:0]         flags_q, flags_d;

  // ---------------------------------------------------------------------------
  // Operand classification (live inputs, only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic [exp-1:0]   exp_a, exp_b;
  logic [frac-1:0]  frac_a, frac_b;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             sign_in;
  logic [ew-1:0]    e_in;
  logic             spec_hit;
  logic [width-1:0] spec_r;
  logic [4:0]       spec_flags;

  localparam logic [width-1:0] qnan = {1'b0, {exp{1'b1}}, 1'b1, {(frac-1){1'b0}}};

  always_comb begin
    exp_a   = a[width-2:frac];
    exp_b   = b[width-2:frac];
    frac_a  = a[frac-1:0];
    frac_b  = b[frac-1:0];
    a_nan   = (&exp_a) && (|frac_a);
    b_nan   = (&exp_b) && (|frac_b);
    a_inf   = (&exp_a) && !(|frac_a);
    b_inf   = (&exp_b) && !(|frac_b);
    // Subnormals are flushed to zero on input, so exp==0 alone means zero.
    a_zero  = (exp_a == '0);
    b_zero  = (exp_b == '0);
    sign_in = a[width-1] ^ b[width-1];
    e_in    = {2'b00, exp_a} + {2'b00, exp_b} - e_bias;

    spec_hit   = 1'b1;
    spec_r     = '0;
    spec_flags = 5'b00000;
    if (a_nan || b_nan) begin
      spec_r     = qnan;
      spec_flags = 5'b10000;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      spec_r     = qnan;
      spec_flags = 5'b10000;
    end else if (a_inf || b_inf) begin
      spec_r = {sign_in, {exp{1'b1}}, {frac{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_r = {sign_in, {(width-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Shift-add step: multiplicand aligned to the current multiplier bit
  // ---------------------------------------------------------------------------
  logic [pw-1:0] addend;

  always_comb begin
    addend = {{(pw-mw){1'b0}}, mant_a_q} << cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Normalize / round / range check on the finished product
  // ---------------------------------------------------------------------------
  logic            hi;
  logic [frac-1:0] m_frac;
  logic            g_bit, r_bit, s_bit;
  logic            inc;
  logic [frac:0]   frac_rnd;
  logic [ew-1:0]   e_n, e_r;
  logic [width-1:0] rnd_r;
  logic [4:0]      rnd_flags;

  always_comb begin
    hi = prod_q[pw-1];
    // The hidden bit is always 1 after normalization, so only the stored
    // fraction is kept; a carry out of it is exactly a carry out of the mantissa.
    m_frac = hi ? prod_q[pw-2 -: frac] : prod_q[pw-3 -: frac];
    g_bit  = hi ? prod_q[frac]        : prod_q[frac-1];
    r_bit  = hi ? prod_q[frac-1]      : prod_q[frac-2];
    s_bit  = hi ? (|prod_q[frac-2:0]) : (|prod_q[frac-3:0]);
    e_n    = e_q + (hi ? ew'(1) : ew'(0));

    inc      = rnd_q && g_bit && (r_bit || s_bit || m_frac[0]);
    frac_rnd = {1'b0, m_frac} + {{frac{1'b0}}, inc};
    e_r      = e_n + {{(ew-1){1'b0}}, frac_rnd[frac]};

    if (!e_r[ew-1] && (e_r >= e_max)) begin
      rnd_r     = {sign_q, {exp{1'b1}}, {frac{1'b0}}};
      rnd_flags = 5'b00101;
    end else if (e_r[ew-1] || (e_r == '0)) begin
      rnd_r     = {sign_q, {(width-1){1'b0}}};
      rnd_flags = 5'b00011;
    end else begin
      rnd_r     = {sign_q, e_r[exp-1:0], frac_rnd[frac-1:0]};
      rnd_flags = {4'b0000, g_bit | r_bit | s_bit};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mant_a_d    = mant_a_q;
    mant_b_d    = mant_b_q;
    prod_d      = prod_q;
    e_d         = e_q;
    sign_d      = sign_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    r_d         = r_q;
    flags_d     = flags_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_a_d = {1'b1, frac_a};
          mant_b_d = {1'b1, frac_b};
          prod_d   = '0;
          cnt_d    = '0;
          e_d      = e_in;
          sign_d   = sign_in;
          rnd_d    = round_mode;
          if (spec_hit) begin
            r_d     = spec_r;
            flags_d = spec_flags;
            state_d = DONE;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (mant_b_q[cnt_q]) begin
          prod_d = prod_q + addend;
        end
        cnt_d = cnt_q + cw'(1);
        if (cnt_q == cw'(frac)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        r_d     = rnd_r;
        flags_d = rnd_flags;
        state_d = DONE;
      end
      DONE: begin
        // out_valid is registered one edge after DONE is entered; it drops on
        // the same edge that completes the handshake.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mant_a_q    <= '0;
      mant_b_q    <= '0;
      prod_q      <= '0;
      e_q         <= '0;
      sign_q      <= 1'b0;
      rnd_q       <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mant_a_q    <= mant_a_d;
      mant_b_q    <= mant_b_d;
      prod_q      <= prod_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      flags_q     <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fmul_seq.sv
// tb/tb_fmul_seq.sv - directed self-checking bench for fmul_seq

module tb_fmul_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        round_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
  logic [4:0]  flags;

  int total = 0;
  int bad   = 0;

  fmul_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .r          (r),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Presents one operation, then waits (bounded) for out_valid.
  // lat counts rising edges after the accept edge.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic rv,
                        output int lat, output logic [31:0] rr, output logic [4:0] ff,
                        output bit busy_ok);
    @(negedge clk);
    a = av; b = bv; round_mode = rv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'hFFFF_FFFF; b = 32'h1234_5678; round_mode = ~rv;
    busy_ok = (in_ready === 1'b0);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid === 1'b1) break;
      if (in_ready !== 1'b0) busy_ok = 1'b0;
    end
    rr = r;
    ff = flags;
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ir_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  int          lat;
  logic [31:0] rr;
  logic [4:0]  ff;
  bit          busy_ok;
  bit          stable_ok;
  bit          seen_out;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; round_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_r",         r,                  32'd0);
    chk("rst_flags",     {27'd0, flags},     32'd0);

    // 3.0 * 2.0 = 6.0
    run_op(32'h40400000, 32'h40000000, 1'b1, lat, rr, ff, busy_ok);
    chk("mul3x2_lat",   lat,           32'd26);
    chk("mul3x2_r",     rr,            32'h40C00000);
    chk("mul3x2_flags", {27'd0, ff},   32'd0);
    chk("mul3x2_busy",  {31'd0, busy_ok}, 32'd1);
    release_out("mul3x2");

    // -3.0 * 2.0 = -6.0
    run_op(32'hC0400000, 32'h40000000, 1'b0, lat, rr, ff, busy_ok);
    chk("neg_r",     rr,          32'hC0C00000);
    chk("neg_flags", {27'd0, ff}, 32'd0);
    release_out("neg");

    // Rounding mode difference
    run_op(32'h3FC00001, 32'h3FC00000, 1'b1, lat, rr, ff, busy_ok);
    chk("rne_r",     rr,          32'h40100001);
    chk("rne_flags", {27'd0, ff}, 32'h01);
    release_out("rne");
    run_op(32'h3FC00001, 32'h3FC00000, 1'b0, lat, rr, ff, busy_ok);
    chk("trunc_r",     rr,          32'h40100000);
    chk("trunc_flags", {27'd0, ff}, 32'h01);
    release_out("trunc");

    // Overflow to Inf
    run_op(32'h7F000000, 32'h40000000, 1'b1, lat, rr, ff, busy_ok);
    chk("ovf_r",     rr,          32'h7F800000);
    chk("ovf_flags", {27'd0, ff}, 32'h05);
    release_out("ovf");

    // Underflow flush keeps sign
    run_op(32'h80800000, 32'h3F000000, 1'b1, lat, rr, ff, busy_ok);
    chk("unf_r",     rr,          32'h80000000);
    chk("unf_flags", {27'd0, ff}, 32'h03);
    release_out("unf");

    // Special cases, one edge latency
    run_op(32'h7F800000, 32'h00000000, 1'b1, lat, rr, ff, busy_ok);
    chk("infx0_lat",   lat,         32'd1);
    chk("infx0_r",     rr,          32'h7FC00000);
    chk("infx0_flags", {27'd0, ff}, 32'h10);
    release_out("infx0");

    run_op(32'hFF800000, 32'h40000000, 1'b1, lat, rr, ff, busy_ok);
    chk("ninf_lat",   lat,         32'd1);
    chk("ninf_r",     rr,          32'hFF800000);
    chk("ninf_flags", {27'd0, ff}, 32'd0);
    release_out("ninf");

    run_op(32'h00000001, 32'h3F800000, 1'b1, lat, rr, ff, busy_ok);
    chk("daz_lat",   lat,         32'd1);
    chk("daz_r",     rr,          32'h00000000);
    chk("daz_flags", {27'd0, ff}, 32'd0);
    release_out("daz");

    run_op(32'h3F800000, 32'h7FC00001, 1'b0, lat, rr, ff, busy_ok);
    chk("nan_lat",   lat,         32'd1);
    chk("nan_r",     rr,          32'h7FC00000);
    chk("nan_flags", {27'd0, ff}, 32'h10);
    release_out("nan");

    // Backpressure: result held, stray in_valid ignored
    run_op(32'h40400000, 32'h40000000, 1'b1, lat, rr, ff, busy_ok);
    chk("bp_r", rr, 32'h40C00000);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000;
      end else begin
        in_valid = 1'b0;
      end
      if (r !== 32'h40C00000 || flags !== 5'd0 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable_ok = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_stable", {31'd0, stable_ok}, 32'd1);
    release_out("bp");
    seen_out = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_out = 1'b1;
    end
    chk("bp_no_stray", {31'd0, seen_out}, 32'd0);

    // Reset in the middle of MUL (counter == 10 on the reset edge)
    @(negedge clk);
    a = 32'h40400000; b = 32'h40000000; round_mode = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ov", {31'd0, out_valid}, 32'd0);
    chk("abort_ir", {31'd0, in_ready},  32'd1);
    seen_out = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_out = 1'b1;
    end
    chk("abort_no_out", {31'd0, seen_out}, 32'd0);

    // Recovery after abort
    run_op(32'h3FC00000, 32'h3FC00000, 1'b1, lat, rr, ff, busy_ok);
    chk("post_lat",   lat,         32'd26);
    chk("post_r",     rr,          32'h40100000);
    chk("post_flags", {27'd0, ff}, 32'd0);
    release_out("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
